// File: rtl/pipe_pkg.sv
// Shared pipeline constants and the forwarding stage-index to select-code mapping.
package pipe_pkg;

   localparam int unsigned FWD_SEL_RF = 0;
   localparam int unsigned REG_ZERO   = 0;

   // Stage k is encoded as k+1 so that 0 stays reserved for the register file.
   function automatic int unsigned stage_to_sel(input int unsigned stage);
      return stage + 1;
   endfunction

endpackage

// File: rtl/fwd_select.sv
// Combinational priority matcher for one EX operand; the youngest matching stage wins.
module fwd_select
   import pipe_pkg::*;
#(
   parameter int unsigned REG_ADDR_W = 5,
   parameter int unsigned NUM_FWD    = 2,
   parameter int unsigned SEL_W      = 2
) (
   input  logic [REG_ADDR_W-1:0]         i_ex_rs,
   input  logic [NUM_FWD*REG_ADDR_W-1:0] i_fwd_rd,
   input  logic [NUM_FWD-1:0]            i_fwd_regwrite,
   input  logic [NUM_FWD-1:0]            i_fwd_ready,
   output logic [SEL_W-1:0]              o_sel_c,
   output logic                          o_sel_not_ready_c
);

   // Scan oldest to youngest so the youngest match overwrites older ones.
   always_comb begin
      o_sel_c           = SEL_W'(FWD_SEL_RF);
      o_sel_not_ready_c = 1'b0;
      for (int k = NUM_FWD - 1; k >= 0; k--) begin
         if (i_fwd_regwrite[k] &&
             (i_fwd_rd[k*REG_ADDR_W +: REG_ADDR_W] != REG_ADDR_W'(REG_ZERO)) &&
             (i_fwd_rd[k*REG_ADDR_W +: REG_ADDR_W] == i_ex_rs)) begin
            o_sel_c           = SEL_W'(stage_to_sel(unsigned'(k)));
            o_sel_not_ready_c = !i_fwd_ready[k];
         end
      end
   end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding selects, countdown scoreboard for long-latency writes, decode stall,
// saturating stall counter and sticky forwarding-protocol error flag.
module fwd_hazard_unit
   import pipe_pkg::*;
#(
   parameter  int unsigned REG_ADDR_W = 5,
   parameter  int unsigned NUM_FWD    = 2,
   parameter  int unsigned MAX_LAT    = 3,
   parameter  int unsigned CNT_W      = 16,
   localparam int unsigned LAT_W      = $clog2(MAX_LAT + 1),
   localparam int unsigned SEL_W      = $clog2(NUM_FWD + 1)
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          id_valid,
   input  logic [REG_ADDR_W-1:0]         id_rs1,
   input  logic [REG_ADDR_W-1:0]         id_rs2,
   input  logic                          issue_valid,
   input  logic                          issue_regwrite,
   input  logic [REG_ADDR_W-1:0]         issue_rd,
   input  logic [LAT_W-1:0]              issue_lat,
   input  logic [REG_ADDR_W-1:0]         ex_rs1,
   input  logic [REG_ADDR_W-1:0]         ex_rs2,
   input  logic [NUM_FWD*REG_ADDR_W-1:0] fwd_rd,
   input  logic [NUM_FWD-1:0]            fwd_regwrite,
   input  logic [NUM_FWD-1:0]            fwd_ready,
   output logic [SEL_W-1:0]              forward_a,
   output logic [SEL_W-1:0]              forward_b,
   output logic                          stall,
   output logic [CNT_W-1:0]              stall_cycles,
   output logic                          fwd_error
);

   localparam int unsigned NUM_REGS = 2 ** REG_ADDR_W;

   logic [LAT_W-1:0] r_busy [NUM_REGS];
   logic [CNT_W-1:0] r_stall_cycles;
   logic             r_fwd_error;

   logic             w_nr_a;
   logic             w_nr_b;
   logic             w_busy_rs1;
   logic             w_busy_rs2;
   logic             w_stall;
   logic             w_issue;
   logic [LAT_W-1:0] w_lat;

   fwd_select #(
      .REG_ADDR_W (REG_ADDR_W),
      .NUM_FWD    (NUM_FWD),
      .SEL_W      (SEL_W)
   ) u_sel_a (
      .i_ex_rs           (ex_rs1),
      .i_fwd_rd          (fwd_rd),
      .i_fwd_regwrite    (fwd_regwrite),
      .i_fwd_ready       (fwd_ready),
      .o_sel_c           (forward_a),
      .o_sel_not_ready_c (w_nr_a)
   );

   fwd_select #(
      .REG_ADDR_W (REG_ADDR_W),
      .NUM_FWD    (NUM_FWD),
      .SEL_W      (SEL_W)
   ) u_sel_b (
      .i_ex_rs           (ex_rs2),
      .i_fwd_rd          (fwd_rd),
      .i_fwd_regwrite    (fwd_regwrite),
      .i_fwd_ready       (fwd_ready),
      .o_sel_c           (forward_b),
      .o_sel_not_ready_c (w_nr_b)
   );

   assign w_busy_rs1 = (id_rs1 != REG_ADDR_W'(REG_ZERO)) && (r_busy[id_rs1] != '0);
   assign w_busy_rs2 = (id_rs2 != REG_ADDR_W'(REG_ZERO)) && (r_busy[id_rs2] != '0);
   assign w_stall    = id_valid && (w_busy_rs1 || w_busy_rs2);

   // Issues presented while stalled are protocol violations and are dropped.
   assign w_issue = issue_valid && issue_regwrite &&
                    (issue_rd != REG_ADDR_W'(REG_ZERO)) && !w_stall;
   assign w_lat   = ({1'b0, issue_lat} > (LAT_W + 1)'(MAX_LAT)) ? LAT_W'(MAX_LAT) : issue_lat;

   // Scoreboard: a fresh issue overrides the decrement of its own entry.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned r = 0; r < NUM_REGS; r++) begin
            r_busy[r] <= '0;
         end
      end else begin
         r_busy[0] <= '0;
         for (int unsigned r = 1; r < NUM_REGS; r++) begin
            if (w_issue && (issue_rd == REG_ADDR_W'(r))) begin
               r_busy[r] <= w_lat;
            end else if (r_busy[r] != '0) begin
               r_busy[r] <= r_busy[r] - LAT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_stall_cycles <= '0;
         r_fwd_error    <= 1'b0;
      end else begin
         if (w_stall && (r_stall_cycles != '1)) begin
            r_stall_cycles <= r_stall_cycles + CNT_W'(1);
         end
         r_fwd_error <= r_fwd_error || w_nr_a || w_nr_b;
      end
   end

   assign stall        = w_stall;
   assign stall_cycles = r_stall_cycles;
   assign fwd_error    = r_fwd_error;

endmodule
